// File: rtl/round_timer.sv
// Countdown timer for the game response phase: 1 s prescaler, loadable seconds limit, BCD view.
// Optional 2 Hz low-time warning blink is built only when ROUND_TIMER_WARN_EN is defined.
module round_timer #(
    parameter int TICK_DIV = 50000000,
    parameter int MAX_SEC  = 99,
    parameter int WARN_SEC = 5
) (
    input  logic       CLOCK,
    input  logic       reset,
    input  logic       load,
    input  logic       clear,
    input  logic       pause,
    input  logic [6:0] limit,
    output logic [6:0] time_left,
    output logic [3:0] tens,
    output logic [3:0] units,
    output logic       tick,
    output logic       end_time,
    output logic       warn
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] HALF = PW'(TICK_DIV / 2 - 1);
    localparam logic [6:0]    MAXV = 7'(MAX_SEC);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [6:0]    time_q, time_d;
    logic          tick_q, tick_d;
    logic          end_q, end_d;
    logic [6:0]    clamped;

    assign clamped = (limit > MAXV) ? MAXV : limit;

    always_ff @(posedge CLOCK) begin
        if (reset) begin
            state_q <= IDLE;
            presc_q <= '0;
            time_q  <= '0;
            tick_q  <= 1'b0;
            end_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            time_q  <= time_d;
            tick_q  <= tick_d;
            end_q   <= end_d;
        end
    end

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        time_d  = time_q;
        tick_d  = 1'b0;
        end_d   = end_q;
        if (load) begin
            time_d  = clamped;
            presc_d = '0;
            end_d   = (clamped == 7'd0);
            state_d = (clamped == 7'd0) ? EXPIRED : RUN;
        end else if (clear) begin
            state_d = IDLE;
            time_d  = '0;
            presc_d = '0;
            end_d   = 1'b0;
        end else begin
            case (state_q)
                RUN, PAUSED: begin
                    if (pause) begin
                        state_d = PAUSED;
                    end else if (presc_q == LAST) begin
                        // Resuming from PAUSED counts on the same edge so no cycle is lost.
                        presc_d = '0;
                        tick_d  = 1'b1;
                        time_d  = time_q - 7'd1;
                        if (time_q == 7'd1) begin
                            state_d = EXPIRED;
                            end_d   = 1'b1;
                        end else begin
                            state_d = RUN;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                        state_d = RUN;
                    end
                end
                EXPIRED: begin
                    time_d = '0;
                    end_d  = 1'b1;
                end
                default: begin
                    end_d = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        time_left = time_q;
        tick      = tick_q;
        end_time  = end_q;
        tens      = 4'(time_q / 7'd10);
        units     = 4'(time_q % 7'd10);
    end

`ifdef ROUND_TIMER_WARN_EN
    logic warn_q, warn_d;

    always_comb begin
        warn_d = 1'b0;
        if (!load && !clear && (state_q == RUN || state_q == PAUSED) &&
            (state_d == RUN || state_d == PAUSED) &&
            time_d != 7'd0 && time_d <= 7'(WARN_SEC)) begin
            if (!pause && (presc_q == HALF || presc_q == LAST))
                warn_d = ~warn_q;
            else
                warn_d = warn_q;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (reset) warn_q <= 1'b0;
        else       warn_q <= warn_d;
    end

    assign warn = warn_q;
`else
    // Keeps the warning parameters referenced when the blink logic is not built.
    logic unused_warn_cfg;
    assign unused_warn_cfg = (WARN_SEC != 0) && (HALF != LAST);
    assign warn = 1'b0;
`endif

endmodule

// File: doc/round_timer.md
Name: round_timer

Overview:
- Countdown timer for the user-response phase of the sequence game; supplies the end_time status consumed by the Controle FSM.
- Prescales the system clock to a 1 s tick, counts a loadable seconds limit down to zero, and exposes the remaining time as binary and as two BCD digits for the datapath HEX decoders.
- Sits beside the Datapath, driven by FSM enable commands (load/clear) and feeding status back to the FSM.

Parameters:
- TICK_DIV, 50000000: clock cycles per second tick (CLOCK_50 rate); must be >= 2.
- MAX_SEC, 99: upper clamp for the loaded limit; must be <= 99.
- WARN_SEC, 5: warning threshold in seconds (used only with the optional feature).

Ports:
- CLOCK  input  1  system clock, 50 MHz; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- load  input  1  start or restart the countdown with limit.
- clear  input  1  abort and return to idle.
- pause  input  1  level; freezes countdown while high.
- limit  input  7  seconds to count (binary).
- time_left  output  7  remaining seconds (binary, registered).
- tens  output  4  BCD tens digit of time_left.
- units  output  4  BCD units digit of time_left.
- tick  output  1  one-cycle pulse on each decrement.
- end_time  output  1  level; high while expired.
- warn  output  1  low-time blink (see Optional Feature).

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset: state IDLE, prescaler 0, time_left 0, tick 0, end_time 0, warn 0; tens/units therefore 0.
- Priority per edge: reset > load > clear > pause > normal counting.
- States: IDLE, RUN, PAUSED, EXPIRED.
- load, any state:
  - time_left <= min(limit, MAX_SEC); prescaler <= 0; tick <= 0; end_time <= 0.
  - Next state RUN if the clamped limit is nonzero.
  - If limit == 0: next state EXPIRED, end_time <= 1 at the same edge.
- clear, any state except under load: state IDLE, time_left <= 0, prescaler <= 0, end_time <= 0.
- RUN:
  - pause high -> PAUSED; prescaler held; no tick.
  - Otherwise prescaler increments each edge.
  - At the edge where prescaler == TICK_DIV-1: prescaler <= 0, tick <= 1 for one cycle, time_left <= time_left-1.
  - If that decrement reaches 0: state EXPIRED and end_time <= 1 on the same edge.
- PAUSED: prescaler and time_left frozen; pause low -> RUN; counting resumes from the held prescaler value, with no lost or extra cycles.
- EXPIRED: time_left stays 0; end_time held high until load, clear or reset; pause ignored.
- IDLE: counters static; pause ignored; end_time 0.
- Decrement latency from load: first tick exactly TICK_DIV edges after the load edge. A limit of N expires N*TICK_DIV edges after load, plus any paused cycles.
- tens/units: combinational binary-to-BCD of the registered time_left (0..99); no extra latency.
- time_left never wraps below 0. Limits above MAX_SEC are clamped, not truncated.
- load during RUN/PAUSED restarts cleanly with the new limit; no tick is issued on that edge.

Optional Feature:
- Macro: ROUND_TIMER_WARN_EN.
- Defined:
  - warn is registered; it is high-capable only in RUN/PAUSED with 0 < time_left <= WARN_SEC.
  - In RUN it toggles when prescaler == TICK_DIV/2-1 and when prescaler == TICK_DIV-1 (2 Hz blink).
  - It holds its value in PAUSED and is forced to 0 otherwise; load and clear force it to 0.
- Undefined: warn tied to 0; no warning logic synthesized.

Test Plan:
- Reset: assert reset 2 cycles mid-count -> time_left=0, tens=0, units=0, end_time=0, tick=0, state IDLE.
- TICK_DIV=4, limit=3, load at edge E0:
  - tick at E4, E8, E12; time_left 3->2->1->0.
  - end_time=1 from E12 and still 1 at E20.
- TICK_DIV=4, limit=2, load at E0, pause high from E2 for 10 cycles -> first tick at E14, second at E18; end_time=1 at E18.
- limit=120 load -> time_left=99, tens=9, units=9. Then limit=0 load -> end_time=1 after that edge, time_left=0.
- Expired, then load limit=5 -> end_time=0 next edge, time_left=5, tick 4 edges later.
- Running at time_left=7, assert clear -> IDLE, time_left=0, no end_time.
- load and clear same edge -> load wins.
- With ROUND_TIMER_WARN_EN, TICK_DIV=4, WARN_SEC=5, limit=6 -> warn stays 0 until time_left=5, then toggles every 2 cycles; warn=0 once EXPIRED.
